// File: rtl/sbox_layer_seq.sv
// -----------------------------------------------------------------------------
// sbox_layer_seq
//   Applies the 4-bit PRESENT S-box (or its inverse) to every nibble of a
//   WIDTH-bit state word, LANES nibbles per clock, over WIDTH/(4*LANES)
//   cycles. Valid/ready handshake on both the input and output sides.
//
//   Build option: define SBOX_LAYER_INV_EN to build the inverse table and
//   let 'mode' select forward (0) / inverse (1). Without it the inverse
//   table is not built, 'mode' is ignored and substitution is always forward.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_data/mode valid
//   in_ready   : block is idle and accepts a word
//   mode       : 0 = forward, 1 = inverse (sampled on accept)
//   in_data    : state to substitute, nibble 0 = bits [3:0]
//   out_valid  : out_data holds the completed result
//   out_ready  : consumer takes the result
//   out_data   : work register (meaningful only while out_valid)
//   busy       : substitution in progress
// -----------------------------------------------------------------------------
module sbox_layer_seq #(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = $clog2(NIB) + 1;
  localparam int LW   = LANES * 4;
  localparam logic [IDXW-1:0]  LANES_I = IDXW'(LANES);
  localparam logic [IDXW-1:0]  NIB_I   = IDXW'(NIB);
  localparam logic [WIDTH-1:0] MASK    = WIDTH'({LW{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [IDXW-1:0]  r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [IDXW-1:0]  w_idx_next;
  logic [IDXW+1:0]  w_shamt;
  logic [LW-1:0]    w_win;
  logic [LW-1:0]    w_sub;
  logic [WIDTH-1:0] w_work_next;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

`ifdef SBOX_LAYER_INV_EN
  logic r_mode;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_sel(input logic [3:0] x, input logic inv);
    return inv ? sbox_inv(x) : sbox_fwd(x);
  endfunction
`else
  // Forward-only build: mode has no function.
  logic w_unused_mode;
  assign w_unused_mode = mode;

  function automatic logic [3:0] sbox_sel(input logic [3:0] x, input logic inv);
    logic unused_inv;
    unused_inv = inv;
    return sbox_fwd(x);
  endfunction
`endif

  // Only LANES S-boxes: shift the active window down to bit 0, substitute,
  // and shift the result back into place under a mask.
  assign w_idx_next = r_idx + LANES_I;
  assign w_shamt    = {r_idx, 2'b00};
  assign w_win      = LW'(r_work >> w_shamt);

  always_comb begin
    w_sub = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef SBOX_LAYER_INV_EN
      w_sub[l*4 +: 4] = sbox_sel(w_win[l*4 +: 4], r_mode);
`else
      w_sub[l*4 +: 4] = sbox_sel(w_win[l*4 +: 4], 1'b0);
`endif
    end
  end

  assign w_work_next = (r_work & ~(MASK << w_shamt)) | (WIDTH'(w_sub) << w_shamt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SBOX_LAYER_INV_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work     <= in_data;
            r_idx      <= '0;
`ifdef SBOX_LAYER_INV_EN
            r_mode     <= mode;
`endif
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_work <= w_work_next;
          r_idx  <= w_idx_next;
          if (w_idx_next == NIB_I) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // No accept in the handoff cycle: in_ready rises only once back in IDLE.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_work;

endmodule

// File: tb/tb_sbox_layer_seq.sv
module tb_sbox_layer_seq;

`ifdef SBOX_LAYER_INV_EN
  localparam bit INV_BUILT = 1'b1;
`else
  localparam bit INV_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic        mode      [2];
  logic        out_ready [2];
  logic [63:0] in_data   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [63:0] out_data  [2];

  // Instance 0: 4 lanes (4 RUN cycles); instance 1: 16 lanes (1 RUN cycle).
  sbox_layer_seq #(.WIDTH(64), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  sbox_layer_seq #(.WIDTH(64), .LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: independent per-nibble table lookup.
  logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                           4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  function automatic logic [63:0] ref_sub(input logic [63:0] d, input logic m);
    logic [63:0] r;
    logic [63:0] t;
    logic [3:0]  n;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      t = d >> (4 * i);
      n = (m && INV_BUILT) ? INV[t[3:0]] : FWD[t[3:0]];
      r = r | (64'(n) << (4 * i));
    end
    return r;
  endfunction

  task automatic wait_idle(input int s);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready[s] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready[s]) chkb("idle_wait", in_ready[s], 1'b1);
  endtask

  // Offer one word to instance s; after accept, scramble the inputs to show
  // they are ignored. Returns the result, cycles to out_valid, busy cycles.
  task automatic run_word(input int s, input logic [63:0] din, input logic md,
                          output logic [63:0] res, output int lat, output int bcnt);
    wait_idle(s);
    in_data[s]  = din;
    mode[s]     = md;
    in_valid[s] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    mode[s]     = ~md;
    in_data[s]  = ~din;
    lat  = -1;
    bcnt = 0;
    res  = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid[s]) begin
        lat = j;
        res = out_data[s];
        break;
      end
      if (busy[s]) bcnt++;
    end
  endtask

  typedef struct {
    logic [63:0] din;
    logic        md;
    logic [63:0] exp;
  } vec_t;

  vec_t        vt [6];
  logic [63:0] res, d, first_res;
  logic        m, seen;
  int          lat, bcnt, low;

  initial begin
    vt[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
    vt[1] = '{64'hC56B90AD3EF84712, 1'b1,
              INV_BUILT ? 64'h0123456789ABCDEF : 64'h40A8ECF7B1239D56};
    vt[2] = '{64'h0, 1'b1, INV_BUILT ? 64'h5555555555555555 : 64'hCCCCCCCCCCCCCCCC};
    vt[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
    vt[4] = '{64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC};
    vt[5] = '{64'h0123456789ABCDEF, 1'b1,
              INV_BUILT ? 64'h5EF8C12DB463079A : 64'hC56B90AD3EF84712};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; mode[s] = 1'b0; in_data[s] = '0; out_ready[s] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chkb("rst_in_ready", in_ready[s], 1'b1);
      chkb("rst_out_valid", out_valid[s], 1'b0);
      chkb("rst_busy", busy[s], 1'b0);
      chk("rst_out_data", out_data[s], 64'h0);
    end
    rst_n = 1'b1;

    // Directed table on the 4-lane instance
    for (int i = 0; i < 6; i++) begin
      run_word(0, vt[i].din, vt[i].md, res, lat, bcnt);
      chk("vec_data", res, vt[i].exp);
      chki("vec_latency", lat, 4);
      chki("vec_busy_cycles", bcnt, 4);
    end

    // Single-cycle instance
    run_word(1, 64'hFFFFFFFFFFFFFFFF, 1'b0, res, lat, bcnt);
    chk("l16_data", res, 64'h2222222222222222);
    chki("l16_latency", lat, 1);
    chki("l16_busy_cycles", bcnt, 1);

    // Random against the model
    for (int i = 0; i < 24; i++) begin
      d = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      run_word(i % 2, d, m, res, lat, bcnt);
      chk("rand_data", res, ref_sub(d, m));
      chki("rand_latency", lat, (i % 2 == 0) ? 4 : 1);
    end

    // Hold in DONE with out_ready low; in_valid pulses must be ignored
    out_ready[0] = 1'b0;
    d = {$urandom, $urandom};
    run_word(0, d, 1'b0, res, lat, bcnt);
    chk("hold_data0", res, ref_sub(d, 1'b0));
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = (k % 2 == 0);
      in_data[0]  = {$urandom, $urandom};
      @(negedge clk);
      chkb("hold_out_valid", out_valid[0], 1'b1);
      chkb("hold_in_ready", in_ready[0], 1'b0);
      chk("hold_out_data", out_data[0], ref_sub(d, 1'b0));
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chkb("release_in_ready", in_ready[0], 1'b1);
    chkb("release_out_valid", out_valid[0], 1'b0);

    // Back-to-back with in_valid held: accepts spaced N+2 cycles apart
    wait_idle(0);
    d = {$urandom, $urandom};
    in_data[0] = d; mode[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk);
    low = 0;
    first_res = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid[0]) first_res = out_data[0];
      if (in_ready[0]) break;
      low++;
    end
    chki("b2b_not_ready_cycles", low, 5);
    chk("b2b_first_data", first_res, ref_sub(d, 1'b0));
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_data[0]  = ~d;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        lat = j;
        res = out_data[0];
        break;
      end
    end
    chki("b2b_second_latency", lat, 4);
    chk("b2b_second_data", res, ref_sub(d, 1'b0));

    // Reset during the second RUN cycle aborts the word
    wait_idle(0);
    d = {$urandom, $urandom};
    in_data[0] = d; mode[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chkb("abort_in_ready", in_ready[0], 1'b1);
    chkb("abort_busy", busy[0], 1'b0);
    chk("abort_out_data", out_data[0], 64'h0);
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      seen = seen | out_valid[0];
    end
    chkb("abort_no_out_valid", seen, 1'b0);
    d = {$urandom, $urandom};
    run_word(0, d, 1'b1, res, lat, bcnt);
    chk("post_abort_data", res, ref_sub(d, 1'b1));
    chki("post_abort_latency", lat, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
